// File: rtl/slicer_deser_pkg.sv
// Shared types and default sizing for the slicer deserializer.
package slicer_deser_pkg;

  localparam int unsigned SLICER_DESER_WIDTH_DEF = 8;
  localparam int unsigned SLICER_DESER_DEPTH_DEF = 4;

  typedef enum logic [0:0] {
    ALIGN_HUNT,
    ALIGN_LOCKED
  } align_state_e;

endpackage

// File: rtl/slicer_deser_if.sv
// Bit-stream input and word-stream output bundle of the slicer deserializer.
interface slicer_deser_if
  import slicer_deser_pkg::*;
#(
  parameter int unsigned WIDTH = SLICER_DESER_WIDTH_DEF,
  parameter int unsigned DEPTH = SLICER_DESER_DEPTH_DEF
) ();

  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  logic              bit_valid;
  logic              bit_in;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [LevelW-1:0] fifo_level;
  logic              overflow;
  logic              locked;

  modport master (
    output bit_valid, bit_in, out_ready,
    input  out_valid, out_data, fifo_level, overflow, locked
  );

  modport slave (
    input  bit_valid, bit_in, out_ready,
    output out_valid, out_data, fifo_level, overflow, locked
  );

endinterface

// File: rtl/slicer_deser_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO succeeds only
// when a pop happens at the same edge.
module slicer_deser_fifo
  import slicer_deser_pkg::*;
#(
  parameter int unsigned WIDTH = SLICER_DESER_WIDTH_DEF,
  parameter int unsigned DEPTH = SLICER_DESER_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0]  wr_q, rd_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LevelW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AddrW'(1);
      end
      if (do_pop) rd_q <= rd_q + AddrW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LevelW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LevelW'(1);
    end
  end

endmodule

// File: rtl/slicer_deser.sv
// Packs the slicer decision stream LSB-first into WIDTH-bit words queued in a FWFT FIFO.
// Define SLICER_DESER_ALIGN_EN to hunt for SYNC_WORD before packing starts.
module slicer_deser
  import slicer_deser_pkg::*;
#(
  parameter int unsigned      WIDTH     = SLICER_DESER_WIDTH_DEF,
  parameter int unsigned      DEPTH     = SLICER_DESER_DEPTH_DEF,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'h47)
) (
  input logic           clk,
  input logic           rst,
  slicer_deser_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             last_bit, run, push, pop, full, empty;
  logic             overflow_q, overflow_d;

  assign sreg_d   = {bus.bit_in, sreg_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

`ifdef SLICER_DESER_ALIGN_EN
  align_state_e state_q;
  logic         locked_q;

  // The window compare includes the bit sampled at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ALIGN_HUNT;
      locked_q <= 1'b0;
    end else if (state_q == ALIGN_HUNT && bus.bit_valid && sreg_d == SYNC_WORD) begin
      state_q  <= ALIGN_LOCKED;
      locked_q <= 1'b1;
    end
  end

  assign run        = (state_q == ALIGN_LOCKED);
  assign bus.locked = locked_q;
`else
  logic unused_sync_word;

  assign unused_sync_word = ^SYNC_WORD;
  assign run              = 1'b1;
  assign bus.locked       = 1'b1;
`endif

  assign push = bus.bit_valid & run & last_bit;
  assign pop  = bus.out_ready & ~empty;

  // While hunting the counter holds at zero, so locking restarts the word boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.bit_valid && run) cnt_d = last_bit ? '0 : cnt_q + CntW'(1);
  end

  assign overflow_d = overflow_q | (push & full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sreg_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.bit_valid) sreg_q <= sreg_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  slicer_deser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (sreg_d),
    .pop_i   (bus.out_ready),
    .data_o  (bus.out_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (bus.fifo_level)
  );

  assign bus.out_valid = ~empty;
  assign bus.overflow  = overflow_q;

endmodule
